// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

    localparam int ADDR_W = 12;
    localparam int INSN_W_DEF = 32;
    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 12'h000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/full_adder12.sv
// 12-bit ripple-carry adder used as the program-counter incrementer.
module full_adder12
    import fetch_pkg::*;
(
    input  logic [ADDR_W-1:0] a,
    input  logic [ADDR_W-1:0] b,
    input  logic              cin,
    output logic [ADDR_W-1:0] sum,
    output logic              cout
);

    logic [ADDR_W:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < ADDR_W; i++) begin : g_bit
        assign sum[i]         = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign cout = carry_s[ADDR_W];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage front end: owns the PC, drives the sync ROM address, hands {insn, pc, pc+1} to decode.
// Optional build macro PC_WRAP_TRAP_EN: a PC wrap past 12'hFFF raises a sticky trap and halts fetch.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int                INSN_W   = INSN_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INSN_W-1:0] imem_data,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              fd_valid,
    input  logic              fd_ready,
    output logic [INSN_W-1:0] fd_insn,
    output logic [ADDR_W-1:0] fd_pc,
    output logic [ADDR_W-1:0] fd_pc_plus1,
    output logic              pc_wrap_err
);

`ifdef PC_WRAP_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    fetch_state_e      state_r;
    fetch_state_e      state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] fetch_pc_nxt_s;
    logic [ADDR_W-1:0] fetch_pc1_r;
    logic [ADDR_W-1:0] fetch_pc1_nxt_s;
    logic              fetch_vld_r;
    logic              fetch_vld_nxt_s;
    logic              wrap_err_r;
    logic              wrap_set_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic              pc_cout_s;
    logic              stall_s;

    full_adder12 u_pc_incr (
        .a    (pc_r),
        .b    (12'd1),
        .cin  (1'b0),
        .sum  (pc_inc_s),
        .cout (pc_cout_s)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-datapath decode; redirect outranks everything but reset.
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        fetch_pc_nxt_s  = fetch_pc_r;
        fetch_pc1_nxt_s = fetch_pc1_r;
        fetch_vld_nxt_s = fetch_vld_r;
        wrap_set_s      = 1'b0;
        if (redirect_en) begin
            state_nxt_s     = RUN;
            pc_nxt_s        = redirect_pc;
            fetch_vld_nxt_s = 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    state_nxt_s = RUN;
                end
                RUN: begin
                    if (halt_req) begin
                        state_nxt_s     = HALT;
                        fetch_vld_nxt_s = 1'b0;
                    end else if (stall_s) begin
                        fetch_vld_nxt_s = fetch_vld_r;
                    end else begin
                        fetch_pc_nxt_s  = pc_r;
                        fetch_pc1_nxt_s = pc_inc_s;
                        fetch_vld_nxt_s = 1'b1;
                        pc_nxt_s        = pc_inc_s;
                        // The wrapping instruction itself is still presented before halting.
                        if (TRAP_EN && pc_cout_s) begin
                            wrap_set_s  = 1'b1;
                            state_nxt_s = HALT;
                        end else begin
                            wrap_set_s  = 1'b0;
                        end
                    end
                end
                HALT: begin
                    if (stall_s) begin
                        fetch_vld_nxt_s = fetch_vld_r;
                    end else begin
                        fetch_vld_nxt_s = 1'b0;
                    end
                end
                default: begin
                    state_nxt_s     = BOOT;
                    fetch_vld_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers and sticky wrap flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r        <= RESET_PC;
            fetch_pc_r  <= 12'h000;
            fetch_pc1_r <= 12'h000;
            fetch_vld_r <= 1'b0;
            wrap_err_r  <= 1'b0;
        end else begin
            pc_r        <= pc_nxt_s;
            fetch_pc_r  <= fetch_pc_nxt_s;
            fetch_pc1_r <= fetch_pc1_nxt_s;
            fetch_vld_r <= fetch_vld_nxt_s;
            wrap_err_r  <= wrap_err_r | wrap_set_s;
        end
    end

    // Output decode; a stalled fetch replays its address so ROM data stays put.
    always_comb begin
        stall_s     = fetch_vld_r & ~fd_ready;
        imem_addr   = stall_s ? fetch_pc_r : pc_r;
        fd_insn     = fetch_vld_r ? imem_data : {INSN_W{1'b0}};
        fd_valid    = fetch_vld_r;
        fd_pc       = fetch_pc_r;
        fd_pc_plus1 = fetch_pc1_r;
        pc_wrap_err = wrap_err_r;
    end

endmodule
